// File: rtl/crc32_frame_check_pkg.sv
// Shared CRC-32 definitions for the frame checker and the key-hash path.
//   CRC32_POLY / CRC32_SEED / CRC32_XOROUT : IEEE 802.3 CRC-32 constants
//   state_t                                : frame checker states
//   rev8()                                 : reverse the bit order of one byte
package crc32_frame_check_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_SEED   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_frame_check_d32_step.sv
// One 32-bit-parallel CRC-32 update, MSB-first, non-reflected polynomial.
// Combinational only.
//   crc_in  : current CRC register
//   data_in : 32 data bits, bit 31 shifted in first
//   crc_out : CRC register after absorbing all 32 bits
module crc32_d32_step
    import crc32_frame_check_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out
);

    always_comb begin : step
        logic [31:0] c;
        logic        fb;
        c  = crc_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = c[31] ^ data_in[31 - i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_frame_check.sv
// Streaming CRC-32 (IEEE 802.3, reflected) frame checker.
// A frame is zero or more payload words followed by one word carrying the
// expected CRC (flagged by data_last). One cycle after the CRC word is
// accepted a single result_valid pulse carries the verdict.
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   data/data_valid/
//   data_last/data_ready: word input with valid/ready handshake;
//                         data[31:24] is the first byte on the wire
//   result_valid        : one-cycle verdict strobe
//   crc_ok, len_err,
//   crc_calc, word_cnt  : verdict fields, held until the next verdict
module crc32_frame_check
    import crc32_frame_check_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] SEED      = CRC32_SEED
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data,
    input  logic        data_valid,
    input  logic        data_last,
    output logic        data_ready,
    output logic        result_valid,
    output logic        crc_ok,
    output logic        len_err,
    output logic [31:0] crc_calc,
    output logic [15:0] word_cnt
);

    state_t      state;
    state_t      state_next;

    logic [31:0] crc_reg;
    logic [31:0] data_refl;
    logic [31:0] step_out;
    logic [31:0] crc_final;
    logic [15:0] acc_cnt;
    logic        acc_len_err;
    logic        pay_hs;
    logic        last_hs;
    logic        overflow;

    assign pay_hs   = data_valid & data_ready & ~data_last;
    assign last_hs  = data_valid & data_ready & data_last;
    assign overflow = ({16'h0, acc_cnt} >= MAX_WORDS);

    // Reflected CRC expressed with the MSB-first engine: each input byte is
    // bit-reversed on the way in.
    assign data_refl = {rev8(data[31:24]), rev8(data[23:16]),
                        rev8(data[15:8]),  rev8(data[7:0])};

    // Full 32-bit reflection = reverse each byte and swap the byte order.
    assign crc_final = {rev8(crc_reg[7:0]),   rev8(crc_reg[15:8]),
                        rev8(crc_reg[23:16]), rev8(crc_reg[31:24])} ^ CRC32_XOROUT;

    crc32_d32_step u_step (
        .crc_in  (crc_reg),
        .data_in (data_refl),
        .crc_out (step_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        data_ready   = 1'b1;
        result_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    state_next = data_last ? ST_RESULT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (data_valid && data_last) begin
                    state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                data_ready   = 1'b0;
                result_valid = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Verdict is captured at the CRC-word handshake so the received word never
    // touches the CRC register; the accumulator restarts from SEED right away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_reg     <= SEED;
            acc_cnt     <= '0;
            acc_len_err <= 1'b0;
            crc_calc    <= '0;
            word_cnt    <= '0;
            len_err     <= 1'b0;
            crc_ok      <= 1'b0;
        end else if (last_hs) begin
            crc_calc    <= crc_final;
            word_cnt    <= acc_cnt;
            len_err     <= acc_len_err;
            crc_ok      <= (crc_final == data) & ~acc_len_err;
            crc_reg     <= SEED;
            acc_cnt     <= '0;
            acc_len_err <= 1'b0;
        end else if (pay_hs) begin
            if (overflow) begin
                acc_len_err <= 1'b1;
            end else begin
                crc_reg <= step_out;
            end
            if (acc_cnt != '1) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
        end else if (state != ST_ACC) begin
            crc_reg     <= SEED;
            acc_cnt     <= '0;
            acc_len_err <= 1'b0;
        end
    end

endmodule
